// File: rtl/fwd_seq_pkg.sv
// Shared types and constants for the 9-2-9 VAE forward-pass sequencer.
// Holds the FSM state encoding, activation select codes, result/weight
// base addresses and the nominal pass length.
package fwd_seq_pkg;

  localparam int N_IN_DEF  = 9;
  localparam int N_LAT_DEF = 2;
  localparam int AW_DEF    = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1_MAC   = 3'd1,
    L1_STORE = 3'd2,
    SAMPLE   = 3'd3,
    L3_MAC   = 3'd4,
    L3_STORE = 3'd5,
    DONE     = 3'd6
  } fwd_state_e;

  localparam logic [1:0] ACT_PASS = 2'b00;
  localparam logic [1:0] ACT_SP2  = 2'b01;
  localparam logic [1:0] ACT_SIG  = 2'b10;

  localparam int RES_BASE_A2  = 4;
  localparam int RES_BASE_OUT = 6;
  localparam int W_BASE_L3    = 2 * N_LAT_DEF * N_IN_DEF;

  // Cycles from accept to the done cycle inclusive: layer 1 (MAC terms plus
  // one store per neuron), the sample steps, layer 3, and the DONE cycle.
  function automatic int pass_len(input int n_in, input int n_lat);
    return 2 * n_lat * (n_in + 1) + n_lat + n_in * (n_lat + 1) + 1;
  endfunction

  localparam int PASS_LEN = pass_len(N_IN_DEF, N_LAT_DEF);

endpackage

// File: rtl/fwd_seq_ctrl_idx_cnt.sv
// fwd_idx_cnt: two-level neuron/term counter shared by layer 1, the sample
// step and layer 3. The inner index walks MAC terms, the outer index walks
// neurons (or latent samples). Limits come in per cycle so one instance
// serves every phase. Next-state values are exported so the sequencer can
// register its output strobes in the same cycle the counters update.
module fwd_idx_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc_inner,
  input  logic          i_inc_outer,
  input  logic [CW-1:0] i_inner_last,
  input  logic [CW-1:0] i_outer_last,
  output logic [CW-1:0] o_inner_nxt,
  output logic [CW-1:0] o_outer_nxt,
  output logic          o_inner_wrap,
  output logic          o_outer_wrap
);

  logic [CW-1:0] r_inner;
  logic [CW-1:0] r_outer;
  logic [CW-1:0] w_inner_nxt;
  logic [CW-1:0] w_outer_nxt;

  assign o_inner_wrap = (r_inner == i_inner_last);
  assign o_outer_wrap = (r_outer == i_outer_last);
  assign o_inner_nxt  = w_inner_nxt;
  assign o_outer_nxt  = w_outer_nxt;

  // Next index values: clear wins, otherwise each level steps and wraps to 0.
  always_comb begin
    w_inner_nxt = r_inner;
    w_outer_nxt = r_outer;
    if (i_clr) begin
      w_inner_nxt = '0;
      w_outer_nxt = '0;
    end else begin
      if (i_inc_inner) begin
        w_inner_nxt = o_inner_wrap ? '0 : r_inner + 1'b1;
      end
      if (i_inc_outer) begin
        w_outer_nxt = o_outer_wrap ? '0 : r_outer + 1'b1;
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inner <= '0;
      r_outer <= '0;
    end else begin
      r_inner <= w_inner_nxt;
      r_outer <= w_outer_nxt;
    end
  end

endmodule

// File: rtl/fwd_seq_ctrl.sv
// fwd_seq_ctrl: sequencer for the time-multiplexed forward pass of the
// 9-2-9 VAE datapath (shared MAC, softplus_squared, sigmoid, XOR_RNG,
// result register file). It only emits control: operand select,
// weight/bias addresses, MAC strobes, activation select and result writes.
//
// Handshake: a pass is accepted on a rising edge where start=1 and ready=1.
// ready is high only in IDLE (and not stalled); busy is high from the cycle
// after acceptance through DONE; done pulses for one cycle at the end.
// start while busy or in DONE is dropped, never queued.
//
// Optional build macro FWD_SEQ_STALL_EN adds a stall input that freezes the
// sequencer and masks all strobes while high; addresses keep their values.
//
// All outputs are registered from the next-state decode, so they always
// reflect the current state register; only the stall mask is combinational.
module fwd_seq_ctrl
  import fwd_seq_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_LAT = N_LAT_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FWD_SEQ_STALL_EN
  input  logic          stall,
`endif
  input  logic          start,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [3:0]    in_sel,
  output logic [AW-1:0] w_addr,
  output logic [3:0]    b_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          bias_en,
  output logic [1:0]    act_sel,
  output logic          rng_step,
  output logic          res_we,
  output logic [3:0]    res_addr,
  output fwd_state_e    o_dbg_state
);

  localparam int CW     = 4;
  localparam int W_BASE = 2 * N_LAT * N_IN;

  localparam logic [CW-1:0] L1_K_LAST  = CW'(N_IN - 1);
  localparam logic [CW-1:0] L1_N_LAST  = CW'(2 * N_LAT - 1);
  localparam logic [CW-1:0] SMP_LAST   = CW'(N_LAT - 1);
  localparam logic [CW-1:0] L3_K_LAST  = CW'(N_LAT - 1);
  localparam logic [CW-1:0] L3_N_LAST  = CW'(N_IN - 1);

  fwd_state_e    r_state;
  fwd_state_e    w_state_nxt;

  logic          w_stall;
  logic          w_accept;
  logic          w_clr;
  logic          w_inc_inner;
  logic          w_inc_outer;
  logic          w_inner_wrap;
  logic          w_outer_wrap;
  logic [CW-1:0] w_inner_last;
  logic [CW-1:0] w_outer_last;
  logic [CW-1:0] w_inner_nxt;
  logic [CW-1:0] w_outer_nxt;

  // Registered outputs and their next-state decode.
  logic          r_ready, w_ready_d;
  logic          r_busy, w_busy_d;
  logic          r_done, w_done_d;
  logic          r_mac_clr, w_mac_clr_d;
  logic          r_mac_en, w_mac_en_d;
  logic          r_bias_en, w_bias_en_d;
  logic          r_rng_step, w_rng_step_d;
  logic          r_res_we, w_res_we_d;
  logic [1:0]    r_act_sel, w_act_sel_d;
  logic [3:0]    r_in_sel, w_in_sel_d;
  logic [AW-1:0] r_waddr, w_waddr_d;
  logic [3:0]    r_baddr, w_baddr_d;
  logic [3:0]    r_raddr, w_raddr_d;

`ifdef FWD_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && start && !w_stall;

  // Term limit depends on the layer; neuron limit depends on the phase.
  assign w_inner_last = (r_state == L3_MAC) ? L3_K_LAST : L1_K_LAST;
  assign w_outer_last = (r_state == SAMPLE)   ? SMP_LAST  :
                        (r_state == L3_STORE) ? L3_N_LAST : L1_N_LAST;

  fwd_idx_cnt #(
    .CW (CW)
  ) u_idx_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_inc_inner  (w_inc_inner),
    .i_inc_outer  (w_inc_outer),
    .i_inner_last (w_inner_last),
    .i_outer_last (w_outer_last),
    .o_inner_nxt  (w_inner_nxt),
    .o_outer_nxt  (w_outer_nxt),
    .o_inner_wrap (w_inner_wrap),
    .o_outer_wrap (w_outer_wrap)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and counter control; a stall freezes everything.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc_inner = 1'b0;
    w_inc_outer = 1'b0;
    if (!w_stall) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_nxt = L1_MAC;
            w_clr       = 1'b1;
          end
        end
        L1_MAC: begin
          w_inc_inner = 1'b1;
          if (w_inner_wrap) w_state_nxt = L1_STORE;
        end
        L1_STORE: begin
          if (w_outer_wrap) begin
            w_state_nxt = SAMPLE;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = L1_MAC;
            w_inc_outer = 1'b1;
          end
        end
        SAMPLE: begin
          if (w_outer_wrap) begin
            w_state_nxt = L3_MAC;
            w_clr       = 1'b1;
          end else begin
            w_inc_outer = 1'b1;
          end
        end
        L3_MAC: begin
          w_inc_inner = 1'b1;
          if (w_inner_wrap) w_state_nxt = L3_STORE;
        end
        L3_STORE: begin
          if (w_outer_wrap) begin
            w_state_nxt = DONE;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = L3_MAC;
            w_inc_outer = 1'b1;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode from the state/indices that take effect at the next edge.
  always_comb begin
    w_ready_d    = 1'b0;
    w_busy_d     = (w_state_nxt != IDLE);
    w_done_d     = 1'b0;
    w_mac_clr_d  = 1'b0;
    w_mac_en_d   = 1'b0;
    w_bias_en_d  = 1'b0;
    w_rng_step_d = 1'b0;
    w_res_we_d   = 1'b0;
    w_act_sel_d  = ACT_PASS;
    w_in_sel_d   = '0;
    w_waddr_d    = '0;
    w_baddr_d    = '0;
    w_raddr_d    = '0;
    case (w_state_nxt)
      IDLE: begin
        w_ready_d = 1'b1;
      end
      L1_MAC: begin
        w_mac_en_d  = 1'b1;
        w_mac_clr_d = (w_inner_nxt == '0);
        w_in_sel_d  = w_inner_nxt;
        w_waddr_d   = AW'(int'(w_outer_nxt) * N_IN + int'(w_inner_nxt));
      end
      L1_STORE: begin
        // Odd layer-1 neurons are the d (variance) neurons.
        w_bias_en_d = 1'b1;
        w_baddr_d   = w_outer_nxt;
        w_act_sel_d = w_outer_nxt[0] ? ACT_SP2 : ACT_PASS;
        w_res_we_d  = 1'b1;
        w_raddr_d   = w_outer_nxt;
      end
      SAMPLE: begin
        w_rng_step_d = 1'b1;
        w_res_we_d   = 1'b1;
        w_act_sel_d  = ACT_PASS;
        w_raddr_d    = 4'(RES_BASE_A2 + int'(w_outer_nxt));
      end
      L3_MAC: begin
        w_mac_en_d  = 1'b1;
        w_mac_clr_d = (w_inner_nxt == '0);
        w_in_sel_d  = w_inner_nxt;
        w_waddr_d   = AW'(W_BASE + int'(w_outer_nxt) * N_LAT + int'(w_inner_nxt));
      end
      L3_STORE: begin
        w_bias_en_d = 1'b1;
        w_baddr_d   = 4'(2 * N_LAT + int'(w_outer_nxt));
        w_act_sel_d = ACT_SIG;
        w_res_we_d  = 1'b1;
        w_raddr_d   = 4'(RES_BASE_OUT + int'(w_outer_nxt));
      end
      DONE: begin
        w_done_d = 1'b1;
      end
      default: begin
        w_busy_d = 1'b0;
      end
    endcase
  end

  // Output registers; ready comes out of reset high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_mac_en   <= 1'b0;
      r_bias_en  <= 1'b0;
      r_rng_step <= 1'b0;
      r_res_we   <= 1'b0;
      r_act_sel  <= ACT_PASS;
      r_in_sel   <= '0;
      r_waddr    <= '0;
      r_baddr    <= '0;
      r_raddr    <= '0;
    end else begin
      r_ready    <= w_ready_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_mac_clr  <= w_mac_clr_d;
      r_mac_en   <= w_mac_en_d;
      r_bias_en  <= w_bias_en_d;
      r_rng_step <= w_rng_step_d;
      r_res_we   <= w_res_we_d;
      r_act_sel  <= w_act_sel_d;
      r_in_sel   <= w_in_sel_d;
      r_waddr    <= w_waddr_d;
      r_baddr    <= w_baddr_d;
      r_raddr    <= w_raddr_d;
    end
  end

  // Strobes are masked while stalled; a held DONE keeps its pulse pending.
  assign ready       = r_ready    && !w_stall;
  assign done        = r_done     && !w_stall;
  assign mac_clr     = r_mac_clr  && !w_stall;
  assign mac_en      = r_mac_en   && !w_stall;
  assign bias_en     = r_bias_en  && !w_stall;
  assign rng_step    = r_rng_step && !w_stall;
  assign res_we      = r_res_we   && !w_stall;
  assign busy        = r_busy;
  assign act_sel     = r_act_sel;
  assign in_sel      = r_in_sel;
  assign w_addr      = r_waddr;
  assign b_addr      = r_baddr;
  assign res_addr    = r_raddr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fwd_seq_ctrl.sv
// Directed testbench for fwd_seq_ctrl. Cycle numbering: the accept edge
// is edge T; "cycle c" is the clock period that ends at edge T+c, sampled on
// the falling edge inside it. Expected values are worked out by hand from
// the pass layout: L1 neuron n in cycles 10n+1..10n+10, samples in 41..42,
// L3 neuron m in cycles 43+3m..45+3m, DONE in cycle 70.
module tb_fwd_seq_ctrl;
  import fwd_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       ready, busy, done;
  logic [3:0] in_sel;
  logic [6:0] w_addr;
  logic [3:0] b_addr;
  logic       mac_clr, mac_en, bias_en, rng_step, res_we;
  logic [1:0] act_sel;
  logic [3:0] res_addr;
  fwd_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Clock and reset-free DUT hookup.
  always #5 clk = ~clk;

  fwd_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FWD_SEQ_STALL_EN
    .stall       (stall),
`endif
    .start       (start),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .in_sel      (in_sel),
    .w_addr      (w_addr),
    .b_addr      (b_addr),
    .mac_clr     (mac_clr),
    .mac_en      (mac_en),
    .bias_en     (bias_en),
    .act_sel     (act_sel),
    .rng_step    (rng_step),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full pass from a start pulse, checking schedule and scoreboard.
  task automatic run_pass(input string tag, input bit extra_starts);
    logic [31:0] exp_q[$];
    int done_c, done_n, we_n, mac_n, clr_n, bias_n, rng_n, bad_addr, miss;
    int w_seen[0:127];
    done_c = 0; done_n = 0; we_n = 0; mac_n = 0; clr_n = 0;
    bias_n = 0; rng_n = 0; bad_addr = 0; miss = 0;
    for (int i = 0; i < 128; i++) w_seen[i] = 0;
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(i);
    check({tag, "_ready_before"}, ready, 1);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      start = extra_starts && (c == 30 || c == 70);
      if (done) begin
        done_n++;
        if (done_c == 0) done_c = c;
      end
      if (res_we) begin
        we_n++;
        if (exp_q.size() == 0) check({tag, "_res_we_extra"}, we_n, 15);
        else check({tag, "_res_addr"}, res_addr, exp_q.pop_front());
      end
      if (mac_en) begin
        mac_n++;
        if (w_addr > 53) bad_addr++;
        else w_seen[w_addr]++;
      end
      if (mac_clr) clr_n++;
      if (mac_clr && !mac_en) bad_addr++;
      if (bias_en) bias_n++;
      if (rng_step) rng_n++;
      case (c)
        1: begin
          check({tag, "_c1_busy"}, busy, 1);
          check({tag, "_c1_ready"}, ready, 0);
          check({tag, "_c1_clr"}, mac_clr, 1);
          check({tag, "_c1_waddr"}, w_addr, 0);
        end
        11: begin
          check({tag, "_n1_clr"}, mac_clr, 1);
          check({tag, "_n1_waddr_first"}, w_addr, 9);
        end
        12: begin
          check({tag, "_n1_clr_off"}, mac_clr, 0);
          check({tag, "_n1_insel1"}, in_sel, 1);
          check({tag, "_n1_waddr10"}, w_addr, 10);
        end
        19: begin
          check({tag, "_n1_en_last"}, mac_en, 1);
          check({tag, "_n1_waddr_last"}, w_addr, 17);
          check({tag, "_n1_insel8"}, in_sel, 8);
        end
        20: begin
          check({tag, "_n1_bias"}, bias_en, 1);
          check({tag, "_n1_mac_off"}, mac_en, 0);
          check({tag, "_n1_baddr"}, b_addr, 1);
          check({tag, "_n1_act"}, act_sel, 1);
        end
        30: check({tag, "_n2_act"}, act_sel, 0);
        41: begin
          check({tag, "_smp_rng"}, rng_step, 1);
          check({tag, "_smp_act"}, act_sel, 0);
        end
        43: begin
          check({tag, "_l3_clr"}, mac_clr, 1);
          check({tag, "_l3_waddr36"}, w_addr, 36);
        end
        44: begin
          check({tag, "_l3_insel1"}, in_sel, 1);
          check({tag, "_l3_waddr37"}, w_addr, 37);
        end
        45: begin
          check({tag, "_l3_baddr4"}, b_addr, 4);
          check({tag, "_l3_act"}, act_sel, 2);
        end
        50: check({tag, "_dbg_l3mac"}, dbg_state, L3_MAC);
        68: check({tag, "_l3_waddr53"}, w_addr, 53);
        69: check({tag, "_l3_baddr12"}, b_addr, 12);
        70: begin
          check({tag, "_c70_busy"}, busy, 1);
          check({tag, "_c70_ready"}, ready, 0);
        end
        71: begin
          check({tag, "_c71_ready"}, ready, 1);
          check({tag, "_c71_busy"}, busy, 0);
        end
        72: check({tag, "_c72_not_queued"}, busy, 0);
        default: ;
      endcase
    end
    start = 1'b0;
    for (int i = 0; i <= 53; i++) if (w_seen[i] != 1) miss++;
    check({tag, "_done_cycle"}, done_c, 70);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_res_we_count"}, we_n, 15);
    check({tag, "_res_q_left"}, exp_q.size(), 0);
    check({tag, "_mac_en_count"}, mac_n, 54);
    check({tag, "_mac_clr_count"}, clr_n, 13);
    check({tag, "_bias_count"}, bias_n, 13);
    check({tag, "_rng_count"}, rng_n, 2);
    check({tag, "_waddr_cover"}, miss, 0);
    check({tag, "_waddr_bad"}, bad_addr, 0);
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_drain"}, ready, 1);
  endtask

  initial begin
    int d0, d1, dn, rdy_n, overlap, saw_done;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_strobes", {mac_en, mac_clr, bias_en, rng_step, res_we}, 0);
    check("idle_addrs", {w_addr, b_addr, res_addr, in_sel, act_sel}, 0);
    check("idle_dbg", dbg_state, IDLE);

    // Single pass with ignored starts while busy and in DONE.
    run_pass("pass1", 1'b1);

    // start held high: one pass every 71 cycles.
    d0 = 0; d1 = 0; dn = 0; rdy_n = 0; overlap = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (dn == 1) d0 = c;
        if (dn == 2) d1 = c;
      end
      if (ready) rdy_n++;
      if (ready && busy) overlap++;
    end
    start = 1'b0;
    check("held_done_count", dn, 2);
    check("held_done_first", d0, 70);
    check("held_done_gap", d1 - d0, 71);
    check("held_ready_cycles", rdy_n, 2);
    check("held_ready_busy", overlap, 0);
    wait_ready("held");

    // Reset mid-pass in L3_MAC.
    saw_done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) saw_done++;
    end
    check("mid_dbg_before", dbg_state, L3_MAC);
    check("mid_mac_before", mac_en, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {mac_en, mac_clr, bias_en, res_we}, 0);
    check("mid_rst_dbg", dbg_state, IDLE);
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid_no_done", saw_done, 0);
    run_pass("after_rst", 1'b0);
    wait_ready("after_rst");

`ifdef FWD_SEQ_STALL_EN
    // Five-cycle stall starting in cycle 20 (L1 store of neuron 1).
    begin
      int sd, bad;
      sd = 0; bad = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 80; c++) begin
        @(negedge clk);
        start = 1'b0;
        stall = (c >= 20 && c <= 24);
        #1;
        if (stall && (mac_en || mac_clr || bias_en || rng_step || res_we || done || ready)) bad++;
        if (c == 22) check("stall_baddr_hold", b_addr, 1);
        if (c == 25) check("stall_bias_resume", bias_en, 1);
        if (done && sd == 0) sd = c;
      end
      stall = 1'b0;
      check("stall_strobes", bad, 0);
      check("stall_done_cycle", sd, 75);
      wait_ready("stall");
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
